membank_arbiter: RTL and testbench
==================================

Name: membank_arbiter

Overview:
- Shares the banked even/odd byte-lane memory/IO port between two masters: CPU (master 0) and DMA engine (master 1).
- Each lane is arbitrated independently every cycle.
- Default policy is CPU priority, with a starvation guard that forces a DMA win after MAXWAIT consecutive denied cycles.
- Sits between the masters and the memory/iosystem address decode. Bank reads have 1-cycle latency; read data is steered back with a per-master valid.

Parameters:
- ADDRBITS, 15: word address width per lane.
- MAXWAIT, 4: consecutive denied DMA cycles before DMA is forced to win. Legal range 1..15.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  [1:0]  per-lane request; bit0 = even, bit1 = odd.
- cpu_we  in  [1:0]  per-lane write (1) / read (0).
- cpu_addr  in  [1:0][ADDRBITS-1:0]  per-lane word address.
- cpu_wdata  in  [1:0][7:0]  per-lane write byte.
- cpu_gnt  out  [1:0]  per-lane grant, same cycle as request.
- cpu_rdata  out  [1:0][7:0]  read return byte.
- cpu_rvalid  out  [1:0]  read return valid, 1 cycle after granted read.
- dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_rdata, dma_rvalid: same widths and meanings as the cpu_* ports, for the DMA engine.
- mem_addr  out  [1:0][ADDRBITS-1:0]  lane address to memory/IO decode.
- mem_we  out  [1:0]  lane write enable.
- mem_wdata  out  [1:0][7:0]  lane write byte.
- mem_rdata  in  [1:0][7:0]  lane read byte, valid 1 cycle after address.

Behaviour:
- Each lane L runs an identical, independent arbiter. No cross-lane coupling; an unaligned access is two independent lane requests.
- Grant is combinational from req and registered state. A granted write commits at the next posedge. For a granted read, data appears on mem_rdata the following cycle.
- At most one of cpu_gnt[L], dma_gnt[L] is high. gnt never asserts without the matching req.
- Mux:
  - mem_addr/mem_we/mem_wdata come from the granted master.
  - With no grant: mem_we[L]=0 and mem_addr[L]=cpu_addr[L].
- Read return:
  - owner_q[L] registers {OWN_NONE, OWN_CPU, OWN_DMA} for granted reads only; writes register OWN_NONE.
  - cpu_rdata[L] = dma_rdata[L] = mem_rdata[L] (broadcast).
  - cpu_rvalid[L] = (owner_q==OWN_CPU); dma_rvalid[L] = (owner_q==OWN_DMA).
  - Each rvalid pulse lasts exactly 1 cycle per granted read; back-to-back reads give back-to-back pulses.
- FSM per lane, states CPU_PRI and DMA_FORCE:
  - CPU_PRI: CPU wins contention. wait_cnt[L] (4 bits) increments on each cycle with dma_req & !dma_gnt. It clears when dma_req is low or DMA is granted.
  - CPU_PRI -> DMA_FORCE: when wait_cnt reaches MAXWAIT-1 and DMA is denied again. The counter saturates at MAXWAIT.
  - DMA_FORCE: DMA wins contention. Leaves for CPU_PRI, with wait_cnt=0, after one DMA grant, or when dma_req drops while still denied.
- Uncontested requests are granted immediately in either state.
- Simultaneous CPU write and DMA read to the same address: only the winner proceeds; no forwarding.
- Reset (asynchronous, any cycle, including mid-read):
  - State CPU_PRI, wait_cnt 0, owner_q OWN_NONE.
  - All rvalid 0; any pending return is dropped.
  - All gnt 0 and mem_we 0 while reset is high.
- Release: the first posedge after reset deasserts may grant.

Optional Feature:
- Macro: MEMBANK_ARBITER_ROUNDROBIN_EN.
- Defined: the FSM and starvation counter are removed. Each lane has a last_winner flop (reset = DMA, so CPU wins the first contention). On contention the master that is not last_winner wins. last_winner updates on every grant.
- Undefined: CPU priority with the MAXWAIT starvation guard, as above.
- Port list is identical in both builds.

Decomposition:
- Package membank_arbiter_pkg:
  - owner_t enum {OWN_NONE, OWN_CPU, OWN_DMA}.
  - arb_state_t enum {CPU_PRI, DMA_FORCE}.
  - Constants LANE_EVEN=0, LANE_ODD=1.
- Sub-module lane_arbiter: one lane's FSM, counter, grant, mux and owner_q. Instantiated twice via generate over LANE_EVEN/LANE_ODD; the top level only wires arrays.

Test Plan:
- CPU-only read, even lane, addr 0x1234:
  - Same cycle: cpu_gnt[0]=1, mem_addr[0]=0x1234, mem_we[0]=0.
  - Next cycle: mem_rdata[0]=0xA5 -> cpu_rvalid[0]=1, cpu_rdata[0]=0xA5, dma_rvalid=0.
- Continuous contention, both lanes, MAXWAIT=4:
  - CPU granted cycles 0-3; DMA granted cycle 4.
  - CPU granted cycles 5-8; DMA granted cycle 9.
  - wait_cnt returns to 0 after each DMA grant.
- Lane independence:
  - CPU writes odd addr 0x0800 data 0x5A while DMA reads even addr 0x1000, same cycle.
  - Both granted; mem_we=2'b10; dma_rvalid[0] pulses next cycle.
- Reset mid-read:
  - DMA read granted at cycle N; reset asserted between the edges before cycle N+1.
  - dma_rvalid stays 0; after release, FSM=CPU_PRI and wait_cnt=0.
- DMA drop:
  - dma_req held high 3 cycles under contention, then low.
  - wait_cnt clears; a new contention needs a full 4 denials before DMA wins.
- With MEMBANK_ARBITER_ROUNDROBIN_EN, continuous contention on even lane:
  - Grants alternate CPU, DMA, CPU, DMA from cycle 0.

Source files
------------

// File: rtl/membank_arbiter_pkg.sv
// rtl/membank_arbiter_pkg.sv - shared types and lane constants for the even/odd bank arbiter
package membank_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_DMA
    } owner_t;

    typedef enum logic {
        CPU_PRI,
        DMA_FORCE
    } arb_state_t;

    localparam int LANE_EVEN = 0;
    localparam int LANE_ODD  = 1;

endpackage

// File: rtl/membank_arbiter_lane_arbiter.sv
// rtl/membank_arbiter_lane_arbiter.sv - one byte lane: grant, starvation guard, mux, read-return owner
// MEMBANK_ARBITER_ROUNDROBIN_EN replaces the CPU-priority FSM with alternating-winner arbitration.
module lane_arbiter
    import membank_arbiter_pkg::*;
#(
    parameter int ADDRBITS = 15,
    parameter int MAXWAIT  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [ADDRBITS-1:0] cpu_addr,
    input  logic [7:0]          cpu_wdata,
    input  logic                dma_req,
    input  logic                dma_we,
    input  logic [ADDRBITS-1:0] dma_addr,
    input  logic [7:0]          dma_wdata,
    output logic                cpu_gnt,
    output logic                dma_gnt,
    output logic [ADDRBITS-1:0] mem_addr,
    output logic                mem_we,
    output logic [7:0]          mem_wdata,
    output logic                cpu_rvalid,
    output logic                dma_rvalid
);

    owner_t owner_q;
    owner_t owner_d;
    logic   contend;
    logic   dma_wins;

    assign contend = cpu_req & dma_req;

`ifdef MEMBANK_ARBITER_ROUNDROBIN_EN
    // Reset to DMA so the CPU takes the first contended cycle.
    logic last_dma_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_dma_q <= 1'b1;
        end else if (cpu_gnt | dma_gnt) begin
            last_dma_q <= dma_gnt;
        end
    end

    assign dma_wins = ~last_dma_q;
`else
    localparam logic [3:0] WAIT_LAST = 4'(MAXWAIT - 1);
    localparam logic [3:0] WAIT_MAX  = 4'(MAXWAIT);

    arb_state_t state_q;
    arb_state_t state_d;
    logic [3:0] wait_q;
    logic [3:0] wait_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CPU_PRI;
            wait_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            CPU_PRI: begin
                if (!dma_req || dma_gnt) begin
                    wait_d = 4'd0;
                end else if (wait_q >= WAIT_LAST) begin
                    state_d = DMA_FORCE;
                    wait_d  = WAIT_MAX;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            DMA_FORCE: begin
                if (!dma_req || dma_gnt) begin
                    state_d = CPU_PRI;
                    wait_d  = 4'd0;
                end
            end
            default: begin
                state_d = CPU_PRI;
                wait_d  = 4'd0;
            end
        endcase
    end

    assign dma_wins = (state_q == DMA_FORCE);
`endif

    // Grants are forced low while reset is held so nothing reaches the bank.
    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (!reset) begin
            if (contend) begin
                dma_gnt = dma_wins;
                cpu_gnt = ~dma_wins;
            end else begin
                cpu_gnt = cpu_req;
                dma_gnt = dma_req;
            end
        end
    end

    always_comb begin
        mem_addr  = dma_gnt ? dma_addr  : cpu_addr;
        mem_wdata = dma_gnt ? dma_wdata : cpu_wdata;
        mem_we    = (cpu_gnt & cpu_we) | (dma_gnt & dma_we);
        owner_d   = OWN_NONE;
        if (cpu_gnt && !cpu_we) begin
            owner_d = OWN_CPU;
        end else if (dma_gnt && !dma_we) begin
            owner_d = OWN_DMA;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    assign cpu_rvalid = (owner_q == OWN_CPU);
    assign dma_rvalid = (owner_q == OWN_DMA);

endmodule

// File: rtl/membank_arbiter.sv
// rtl/membank_arbiter.sv - CPU/DMA arbiter for the even/odd byte-lane memory port
// Build option MEMBANK_ARBITER_ROUNDROBIN_EN selects round-robin lane arbitration.
module membank_arbiter
    import membank_arbiter_pkg::*;
#(
    parameter int ADDRBITS = 15,
    parameter int MAXWAIT  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               cpu_req,
    input  logic [1:0]               cpu_we,
    input  logic [1:0][ADDRBITS-1:0] cpu_addr,
    input  logic [1:0][7:0]          cpu_wdata,
    output logic [1:0]               cpu_gnt,
    output logic [1:0][7:0]          cpu_rdata,
    output logic [1:0]               cpu_rvalid,
    input  logic [1:0]               dma_req,
    input  logic [1:0]               dma_we,
    input  logic [1:0][ADDRBITS-1:0] dma_addr,
    input  logic [1:0][7:0]          dma_wdata,
    output logic [1:0]               dma_gnt,
    output logic [1:0][7:0]          dma_rdata,
    output logic [1:0]               dma_rvalid,
    output logic [1:0][ADDRBITS-1:0] mem_addr,
    output logic [1:0]               mem_we,
    output logic [1:0][7:0]          mem_wdata,
    input  logic [1:0][7:0]          mem_rdata
);

    // Read data is broadcast; only the rvalid strobes identify the owner.
    assign cpu_rdata = mem_rdata;
    assign dma_rdata = mem_rdata;

    for (genvar l = LANE_EVEN; l <= LANE_ODD; l++) begin : g_lane
        lane_arbiter #(
            .ADDRBITS (ADDRBITS),
            .MAXWAIT  (MAXWAIT)
        ) u_lane (
            .clk        (clk),
            .reset      (reset),
            .cpu_req    (cpu_req[l]),
            .cpu_we     (cpu_we[l]),
            .cpu_addr   (cpu_addr[l]),
            .cpu_wdata  (cpu_wdata[l]),
            .dma_req    (dma_req[l]),
            .dma_we     (dma_we[l]),
            .dma_addr   (dma_addr[l]),
            .dma_wdata  (dma_wdata[l]),
            .cpu_gnt    (cpu_gnt[l]),
            .dma_gnt    (dma_gnt[l]),
            .mem_addr   (mem_addr[l]),
            .mem_we     (mem_we[l]),
            .mem_wdata  (mem_wdata[l]),
            .cpu_rvalid (cpu_rvalid[l]),
            .dma_rvalid (dma_rvalid[l])
        );
    end

endmodule

// File: tb/tb_membank_arbiter.sv
// tb/tb_membank_arbiter.sv - directed self-checking bench for membank_arbiter
module tb_membank_arbiter;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [1:0][14:0] cpu_addr;
    logic [1:0][7:0]  cpu_wdata, cpu_rdata;
    logic [1:0]       dma_req, dma_we, dma_gnt, dma_rvalid;
    logic [1:0][14:0] dma_addr;
    logic [1:0][7:0]  dma_wdata, dma_rdata;
    logic [1:0][14:0] mem_addr;
    logic [1:0]       mem_we;
    logic [1:0][7:0]  mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    membank_arbiter #(.ADDRBITS(15), .MAXWAIT(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        cpu_req = 2'b00; cpu_we = 2'b00; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 2'b00; dma_we = 2'b00; dma_addr = '0; dma_wdata = '0;
        mem_rdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Both lanes contend with reads for n cycles; DMA expected on cycles dma_at, 2*dma_at+1, ...
    task automatic run_contention(input string tag, input int n, input int dma_at);
        logic [1:0] ed, ec, prev_ec, prev_ed;
        prev_ec = 2'b00;
        prev_ed = 2'b00;
        cpu_req = 2'b11; dma_req = 2'b11; cpu_we = 2'b00; dma_we = 2'b00;
        for (int c = 0; c < n; c++) begin
            #1;
`ifdef MEMBANK_ARBITER_ROUNDROBIN_EN
            ed = (c % 2 == 1) ? 2'b11 : 2'b00;
`else
            ed = (dma_at >= 0 && (c % (dma_at + 1)) == dma_at) ? 2'b11 : 2'b00;
`endif
            ec = ~ed;
            chk({tag, "_cpu_gnt"}, cpu_gnt, ec);
            chk({tag, "_dma_gnt"}, dma_gnt, ed);
            if (c > 0) begin
                chk({tag, "_cpu_rvalid"}, cpu_rvalid, prev_ec);
                chk({tag, "_dma_rvalid"}, dma_rvalid, prev_ed);
            end
            prev_ec = ec;
            prev_ed = ed;
            @(negedge clk);
        end
        cpu_req = 2'b00; dma_req = 2'b00;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        cpu_req = 2'b11; cpu_we = 2'b11; dma_req = 2'b11;
        repeat (2) @(negedge clk);
        chk("rst_cpu_gnt", cpu_gnt, 2'b00);
        chk("rst_dma_gnt", dma_gnt, 2'b00);
        chk("rst_mem_we", mem_we, 2'b00);
        chk("rst_rvalid", {cpu_rvalid, dma_rvalid}, 4'b0000);
        do_reset();

`ifdef MEMBANK_ARBITER_ROUNDROBIN_EN
        run_contention("rr", 6, 1);
`else
        // Idle lane: address follows the CPU, no write strobe
        cpu_we = 2'b11; cpu_addr[0] = 15'h0123; cpu_addr[1] = 15'h0456;
        #1;
        chk("idle_mem_we", mem_we, 2'b00);
        chk("idle_mem_addr0", mem_addr[0], 15'h0123);
        chk("idle_mem_addr1", mem_addr[1], 15'h0456);

        // CPU-only read on the even lane
        @(negedge clk);
        clear_inputs();
        cpu_req = 2'b01; cpu_addr[0] = 15'h1234;
        #1;
        chk("rd_cpu_gnt", cpu_gnt, 2'b01);
        chk("rd_mem_addr", mem_addr[0], 15'h1234);
        chk("rd_mem_we", mem_we, 2'b00);
        @(negedge clk);
        cpu_req = 2'b00; mem_rdata[0] = 8'hA5;
        #1;
        chk("rd_cpu_rvalid", cpu_rvalid, 2'b01);
        chk("rd_cpu_rdata", cpu_rdata[0], 8'hA5);
        chk("rd_dma_rvalid", dma_rvalid, 2'b00);
        @(negedge clk);
        #1;
        chk("rd_pulse_end", cpu_rvalid, 2'b00);

        // Continuous contention: DMA forced on cycles 4 and 9
        do_reset();
        run_contention("cont", 10, 4);

        // Lane independence: CPU odd write, DMA even read
        @(negedge clk);
        cpu_req = 2'b10; cpu_we = 2'b10; cpu_addr[1] = 15'h0800; cpu_wdata[1] = 8'h5A;
        dma_req = 2'b01; dma_we = 2'b00; dma_addr[0] = 15'h1000;
        #1;
        chk("ind_cpu_gnt", cpu_gnt, 2'b10);
        chk("ind_dma_gnt", dma_gnt, 2'b01);
        chk("ind_mem_we", mem_we, 2'b10);
        chk("ind_addr_odd", mem_addr[1], 15'h0800);
        chk("ind_wdata_odd", mem_wdata[1], 8'h5A);
        chk("ind_addr_even", mem_addr[0], 15'h1000);
        @(negedge clk);
        clear_inputs();
        #1;
        chk("ind_dma_rvalid", dma_rvalid, 2'b01);
        chk("ind_cpu_rvalid", cpu_rvalid, 2'b00);

        // Reset before the capturing edge drops the pending return
        do_reset();
        dma_req = 2'b01; dma_addr[0] = 15'h0042;
        #1;
        chk("mid_dma_gnt", dma_gnt, 2'b01);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_gnt_in_rst", dma_gnt, 2'b00);
        @(posedge clk);
        #1;
        chk("mid_dma_rvalid", dma_rvalid, 2'b00);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        dma_req = 2'b00;
        #1;
        chk("async_rvalid_set", dma_rvalid, 2'b01);
        reset = 1'b1;
        #1;
        chk("async_rvalid_clr", dma_rvalid, 2'b00);

        // Starvation count is cleared by reset
        do_reset();
        run_contention("rst_pre", 3, -1);
        do_reset();
        run_contention("rst_post", 5, 4);

        // Dropping dma_req clears the count
        do_reset();
        run_contention("drop_pre", 3, -1);
        #1;
        chk("drop_idle_gnt", {cpu_gnt, dma_gnt}, 4'b0000);
        @(negedge clk);
        run_contention("drop_post", 5, 4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
